lsu_byte_seq: RTL and testbench
===============================

# lsu_byte_seq

Load/store sequencer between the RV32I core's execute stage and the byte-wide data memory. It accepts one load or store per handshake and splits it into 1, 2 or 4 little-endian byte transfers. For loads it assembles the returned bytes and sign- or zero-extends them per funct3. Misaligned or illegal accesses are flagged without touching memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core presents an access
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code (loads 000/001/010/100/101; stores 000/001/010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle pulse, access complete
- resp_rdata  out  32  extended load data; held until next resp_valid
- resp_misaligned  out  1  valid with resp_valid; 1 = access rejected
- mem_addr  out  32  byte address to data memory
- mem_we  out  1  byte write strobe
- mem_din  out  8  byte write data
- mem_dout  in  8  byte read data; synchronous read, valid the cycle after mem_addr

## Operation
- Byte count N: funct3[1:0] 00→1, 01→2, 10→4. Byte i maps to address base+i and data bits [8i+7:8i].
- On accept, latch addr, wdata, funct3 and we; clear the byte counter cnt.
- Reject condition:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Load funct3 011/110/111.
  - Store funct3 with bit 2 set or 011.
  - On reject: go straight to DONE with resp_misaligned=1 and resp_rdata=0. No memory cycle occurs.
- States:
  - IDLE: req_ready=1. Accept → XFER, or → DONE if rejected.
  - XFER: mem_addr=base+cnt. Stores drive mem_we=1 and mem_din=wdata byte cnt. Loads capture mem_dout into byte cnt−1 when cnt>0. cnt increments each cycle. When cnt==N−1: store → DONE, load → LWAIT.
  - LWAIT (loads only): capture mem_dout into byte N−1; mem_we=0 → DONE.
  - DONE: resp_valid=1. resp_rdata = assembled value extended to 32 bits: sign-extend from bit 8N−1 when funct3[2]=0, zero-extend when funct3[2]=1 (LW has no extension). → IDLE.
- mem_we is 0 outside XFER-with-store. mem_we is forced 0 whenever rst is high.
- While not IDLE, req_valid is ignored; the core holds the request until it is accepted.
- No back-to-back acceptance: at least one IDLE cycle separates responses.

## Timing
- Cycle 0 is the accept edge.
- Store: byte writes in cycles 1..N; resp_valid in cycle N+1.
- Load: addresses in cycles 1..N; last byte captured in cycle N+1; resp_valid in cycle N+2.
- Rejected access: resp_valid in cycle 1.
- Reset values: state=IDLE, req_ready=1 (from the first cycle after reset), resp_valid=0, resp_misaligned=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_din=0, cnt=0.
- Reset mid-access: abort immediately. Bytes already written stay written; no response is issued; IDLE on the next cycle.
- Address increment is a plain 32-bit add. Wrap at 0xFFFFFFFF is impossible for aligned accesses.

## Structure
- Shared core package holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State encoding (IDLE, XFER, LWAIT, DONE).
  - Helper computing N from funct3.
- One natural sub-module: lsu_extend. It is combinational and takes the 32-bit assembled value, N and funct3[2], and produces the extended word. The sequencer registers its output in DONE.

## Test plan
Memory preload: 0x100..0x103 = 80 12 34 F6.
- LW 0x100 → resp_valid in cycle 6, resp_rdata=0xF6341280, resp_misaligned=0.
- LB 0x100 → cycle 3, 0xFFFFFF80. LBU 0x100 → 0x00000080.
- LH 0x102 → cycle 4, 0xFFFFF634. LHU 0x102 → 0x0000F634.
- SW 0x200, wdata 0xDEADBEEF → mem_we in cycles 1–4 with (0x200,EF), (0x201,BE), (0x202,AD), (0x203,DE). resp_valid in cycle 5. A following LW 0x200 returns 0xDEADBEEF.
- SH 0x101 → resp_valid with resp_misaligned=1 in cycle 1, resp_rdata=0, mem_we never high. Load funct3=011 behaves the same.
- SW 0x300, wdata 0x11223344, rst high in cycle 2 → only 0x300=0x44 is written. No resp_valid. req_ready=1 in cycle 3.

Source files
------------

// File: rtl/lsu_byte_seq_pkg.sv
// Shared definitions for the byte-wide load/store sequencer.
package lsu_byte_seq_pkg;

  // RV32I funct3 width/sign codes (loads and stores share encodings)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    LWAIT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of bytes moved by an access (1, 2 or 4)
  function automatic logic [2:0] nbytes(input logic [2:0] f3);
    logic [2:0] n;
    case (f3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Misaligned or unsupported encodings never reach memory
  function automatic logic is_reject(input logic we, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic rej;
    rej = 1'b1;
    if (we) begin
      case (f3)
        F3_SB:   rej = 1'b0;
        F3_SH:   rej = addr_lo[0];
        F3_SW:   rej = |addr_lo;
        default: rej = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: rej = 1'b0;
        F3_LH, F3_LHU: rej = addr_lo[0];
        F3_LW:         rej = |addr_lo;
        default:       rej = 1'b1;
      endcase
    end
    return rej;
  endfunction

endpackage

// File: rtl/lsu_byte_seq_extend.sv
// Sign/zero extension of an assembled 1/2/4-byte load value.
module lsu_extend
  import lsu_byte_seq_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_nbytes,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  // Replicate the top data bit of the access (or zero) into the upper bits
  always_comb begin
    o_data = i_data;
    case (i_nbytes)
      3'd1:    o_data = {{24{~i_unsigned & i_data[7]}},  i_data[7:0]};
      3'd2:    o_data = {{16{~i_unsigned & i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer: splits one core access into little-endian byte
// transfers to a byte-wide synchronous memory and assembles load data.
//
// state | meaning
// IDLE  | ready for a request
// XFER  | one byte address per cycle; stores write, loads capture previous byte
// LWAIT | loads only: capture last byte returned by the memory
// DONE  | one-cycle response pulse
module lsu_byte_seq
  import lsu_byte_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic        r_we;
  logic [1:0]  r_cnt;
  logic [31:0] r_data;
  logic [31:0] r_rdata;
  logic        r_mis;

  logic        w_reject;
  logic [2:0]  w_nbytes;
  logic [1:0]  w_last_cnt;
  logic        w_at_last;
  logic [1:0]  w_cap_idx;
  logic [31:0] w_merge;
  logic [31:0] w_ext;

  assign w_reject  = is_reject(req_we, req_funct3, req_addr[1:0]);
  assign w_nbytes  = nbytes(r_f3);
  assign w_at_last = (r_cnt == w_last_cnt);

  // Index of the final byte of the latched access
  always_comb begin
    case (r_f3[1:0])
      2'b00:   w_last_cnt = 2'd0;
      2'b01:   w_last_cnt = 2'd1;
      default: w_last_cnt = 2'd3;
    endcase
  end

  // Memory data lags the address by one cycle, so XFER stores into byte
  // cnt-1 and LWAIT stores the final byte.
  always_comb begin
    w_cap_idx = (r_state == XFER) ? (r_cnt - 2'd1) : w_last_cnt;
    w_merge   = r_data;
    w_merge[{w_cap_idx, 3'b000} +: 8] = mem_dout;
  end

  lsu_extend u_extend (
    .i_data     (w_merge),
    .i_nbytes   (w_nbytes),
    .i_unsigned (r_f3[2]),
    .o_data     (w_ext)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake/memory outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_addr    = 32'd0;
    mem_we      = 1'b0;
    mem_din     = 8'd0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_reject ? DONE : XFER;
      end
      XFER: begin
        mem_addr = r_base + {30'd0, r_cnt};
        if (r_we) begin
          mem_we  = ~rst;
          mem_din = r_wdata[{r_cnt, 3'b000} +: 8];
        end
        if (w_at_last) w_state_nxt = r_we ? DONE : LWAIT;
      end
      LWAIT: w_state_nxt = DONE;
      DONE: begin
        resp_valid  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, byte counter, load assembly and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base  <= 32'd0;
      r_wdata <= 32'd0;
      r_f3    <= 3'd0;
      r_we    <= 1'b0;
      r_cnt   <= 2'd0;
      r_data  <= 32'd0;
      r_rdata <= 32'd0;
      r_mis   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_base  <= req_addr;
            r_wdata <= req_wdata;
            r_f3    <= req_funct3;
            r_we    <= req_we;
            r_cnt   <= 2'd0;
            r_data  <= 32'd0;
            r_mis   <= w_reject;
            if (w_reject) r_rdata <= 32'd0;
          end
        end
        XFER: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_we && (r_cnt != 2'd0)) r_data <= w_merge;
          if (r_we && w_at_last) r_rdata <= 32'd0;
        end
        LWAIT: begin
          r_data  <= w_merge;
          r_rdata <= w_ext;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata      = r_rdata;
  assign resp_misaligned = r_mis;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Self-checking bench for lsu_byte_seq with a byte memory and a
// transaction-level reference model.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  lsu_byte_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory with synchronous read; backdoor port used for preload
  logic [7:0] dmem [0:1023];
  logic       bd_we = 1'b0;
  logic [9:0] bd_a = 10'd0;
  logic [7:0] bd_d = 8'd0;
  always @(posedge clk) begin
    if (bd_we) dmem[bd_a] <= bd_d;
    else if (mem_we) dmem[mem_addr[9:0]] <= mem_din;
    mem_dout <= dmem[mem_addr[9:0]];
  end

  // Reference model state
  typedef struct { int cyc; int acc; logic [31:0] rdata; logic mis; } resp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } wr_t;
  resp_t      rq[$];
  wr_t        wq[$];
  logic [7:0] ref_mem [0:1023];

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] held = 32'd0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_mis = 1'b0;
  int          last_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit model_reject(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = model_n(f3);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic int model_n(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int     n;
    n = model_n(f3);
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[(a + i) % 1024]) << (8 * i);
    if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 1) != 0)
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // Present one request; abort_k > 0 means reset will be raised in that cycle
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int abort_k);
    int acc;
    int n;
    logic [7:0] b;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cyc;
    n = model_n(f3);
    if (model_reject(we, f3, addr)) begin
      rq.push_back('{acc, acc, 32'd0, 1'b1});
    end else if (we) begin
      for (int i = 0; i < n; i++) begin
        if (abort_k == 0 || (i + 1) < abort_k) begin
          b = 8'((wdata >> (8 * i)) & 32'hFF);
          wq.push_back('{acc + i, addr + i, b});
          ref_mem[(addr + i) % 1024] = b;
        end
      end
      if (abort_k == 0) rq.push_back('{acc + n, acc, 32'd0, 1'b0});
    end else begin
      rq.push_back('{acc + n + 1, acc, model_load(f3, addr), 1'b0});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (rq.size() == 0 && wq.size() == 0) break;
      @(posedge clk);
    end
    check("drain_pending", rq.size() + wq.size(), 32'd0);
    rq.delete();
    wq.delete();
  endtask

  task automatic expect_last(input string name, input logic [31:0] rdata,
                             input logic mis, input int lat);
    check({name, "_rdata"}, last_rdata, rdata);
    check({name, "_mis"}, {31'd0, last_mis}, {31'd0, mis});
    check({name, "_latency"}, last_lat, lat);
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Per-cycle comparison against the model queues
  always @(negedge clk) begin
    if (rst) begin
      held = 32'd0;
    end else begin
      if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        check("resp_valid_pulse", {31'd0, resp_valid}, 32'd1);
        check("resp_rdata", resp_rdata, rq[0].rdata);
        check("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, rq[0].mis});
        held       = rq[0].rdata;
        last_rdata = resp_rdata;
        last_mis   = resp_misaligned;
        last_lat   = cyc - rq[0].acc + 1;
        void'(rq.pop_front());
      end else begin
        check("resp_valid_quiet", {31'd0, resp_valid}, 32'd0);
      end
      if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        check("mem_we_write", {31'd0, mem_we}, 32'd1);
        check("mem_addr_write", mem_addr, wq[0].addr);
        check("mem_din_write", {24'd0, mem_din}, {24'd0, wq[0].data});
        void'(wq.pop_front());
      end else begin
        check("mem_we_quiet", {31'd0, mem_we}, 32'd0);
      end
      check("resp_rdata_held", resp_rdata, held);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) preload(10'h100 + 10'(i), 8'h00);
    preload(10'h100, 8'h80); preload(10'h101, 8'h12);
    preload(10'h102, 8'h34); preload(10'h103, 8'hF6);
    for (int i = 0; i < 8; i++) preload(10'h200 + 10'(i), 8'h00);
    for (int i = 0; i < 4; i++) preload(10'h300 + 10'(i), 8'h00);

    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_mis", {31'd0, resp_misaligned}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", {24'd0, mem_din}, 32'd0);
    rst = 1'b0;
    @(posedge clk);

    issue(1'b0, 3'b010, 32'h100, 32'd0, 0); drain();
    expect_last("LW_100", 32'hF6341280, 1'b0, 6);
    issue(1'b0, 3'b000, 32'h100, 32'd0, 0); drain();
    expect_last("LB_100", 32'hFFFFFF80, 1'b0, 3);
    issue(1'b0, 3'b100, 32'h100, 32'd0, 0); drain();
    expect_last("LBU_100", 32'h00000080, 1'b0, 3);
    issue(1'b0, 3'b001, 32'h102, 32'd0, 0); drain();
    expect_last("LH_102", 32'hFFFFF634, 1'b0, 4);
    issue(1'b0, 3'b101, 32'h102, 32'd0, 0); drain();
    expect_last("LHU_102", 32'h0000F634, 1'b0, 4);
    issue(1'b0, 3'b101, 32'h100, 32'd0, 0); drain();
    expect_last("LHU_100", 32'h00001280, 1'b0, 4);

    issue(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 0); drain();
    expect_last("SW_200", 32'h0, 1'b0, 5);
    issue(1'b0, 3'b010, 32'h200, 32'd0, 0); drain();
    expect_last("LW_200", 32'hDEADBEEF, 1'b0, 6);

    issue(1'b1, 3'b001, 32'h101, 32'h12345678, 0); drain();
    expect_last("SH_101_rej", 32'h0, 1'b1, 1);
    issue(1'b0, 3'b011, 32'h100, 32'd0, 0); drain();
    expect_last("LD_f3_011_rej", 32'h0, 1'b1, 1);
    issue(1'b0, 3'b010, 32'h202, 32'd0, 0); drain();
    expect_last("LW_202_rej", 32'h0, 1'b1, 1);
    issue(1'b1, 3'b100, 32'h200, 32'h0, 0); drain();
    expect_last("ST_f3_100_rej", 32'h0, 1'b1, 1);

    issue(1'b1, 3'b000, 32'h205, 32'h000000A5, 0); drain();
    expect_last("SB_205", 32'h0, 1'b0, 2);
    issue(1'b0, 3'b000, 32'h205, 32'd0, 0); drain();
    expect_last("LB_205", 32'hFFFFFFA5, 1'b0, 3);
    issue(1'b1, 3'b001, 32'h206, 32'hCAFE1234, 0); drain();
    issue(1'b0, 3'b001, 32'h206, 32'd0, 0); drain();
    expect_last("LH_206", 32'h00001234, 1'b0, 4);
    issue(1'b0, 3'b010, 32'h204, 32'd0, 0); drain();
    expect_last("LW_204", 32'h1234A500, 1'b0, 6);

    issue(1'b1, 3'b010, 32'h300, 32'h11223344, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req_ready_c3", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid_c3", {31'd0, resp_valid}, 32'd0);
    check("abort_byte0", {24'd0, dmem[10'h300]}, 32'h44);
    check("abort_byte1", {24'd0, dmem[10'h301]}, 32'h00);
    drain();
    repeat (3) @(posedge clk);
    issue(1'b0, 3'b010, 32'h300, 32'd0, 0); drain();
    expect_last("LW_300_after_abort", 32'h00000044, 1'b0, 6);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
